// File: rtl/perip_responder_pkg.sv
// Shared definitions for the peripheral responder: register offsets, store
// size encodings, UART state encoding, USTAT bit layout and store merging.
package perip_responder_pkg;

  // Register offsets inside the 256-byte window.
  localparam logic [7:0] OFF_SW    = 8'h00;
  localparam logic [7:0] OFF_LED   = 8'h04;
  localparam logic [7:0] OFF_SEG   = 8'h08;
  localparam logic [7:0] OFF_TCTRL = 8'h0C;
  localparam logic [7:0] OFF_TVAL  = 8'h10;
  localparam logic [7:0] OFF_UDATA = 8'h14;
  localparam logic [7:0] OFF_USTAT = 8'h18;

  // Store size encodings carried on perip_mask[1:0].
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // USTAT field positions.
  localparam int USTAT_BUSY  = 0;
  localparam int USTAT_FULL  = 1;
  localparam int USTAT_EMPTY = 2;
  localparam int USTAT_LVL   = 3;
  localparam int USTAT_OVF   = 6;

  // Merge an unshifted store into a 32-bit register; misaligned halves and
  // words leave the register untouched.
  function automatic logic [31:0] merge_store(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] res;
    res = cur;
    case (size)
      SZ_BYTE: res[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[0] == 1'b0) begin
          res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
          res = cur;
        end
      end
      SZ_WORD: begin
        if (lane == 2'b00) begin
          res = wdata;
        end else begin
          res = cur;
        end
      end
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/perip_responder_uart_tx_core.sv
// UART transmitter: small TX FIFO, baud counter and START/DATA/STOP framer.
// Back-to-back frames are sent with no idle gap while the FIFO has data.
module uart_tx_core
  import perip_responder_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 32'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             busy,
  output logic             txd
);

  localparam int PW = (FIFO_DEPTH > 32'd1) ? $clog2(FIFO_DEPTH) : 32'd1;
  localparam int BW = (BAUD_DIV > 32'd1) ? $clog2(BAUD_DIV) : 32'd1;
  localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_DIV - 32'd1);
  localparam logic [BW-1:0]    BAUD_ONE  = BW'(32'd1);
  localparam logic [BW-1:0]    BAUD_ZERO = BW'(32'd0);
  localparam logic [PW-1:0]    PTR_ONE   = PW'(32'd1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(32'd1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] count_r;
  uart_state_e      state_r, state_s;
  logic [BW-1:0]    baud_r, baud_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             txd_r, txd_s;
  logic             pop_s, push_ok_s, full_s, empty_s, baud_done_s;

  assign full_s      = (count_r == LVL_FULL);
  assign empty_s     = (count_r == {LVL_W{1'b0}});
  assign push_ok_s   = push & ~full_s;
  assign baud_done_s = (baud_r == BAUD_LAST);

  // FIFO storage; contents need no reset because count_r gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // FIFO pointers and occupancy; a push on a full FIFO is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + LVL_ONE;
        2'b01:   count_r <= count_r - LVL_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Framer state register; reset forces the line idle high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= UART_IDLE;
      baud_r  <= BAUD_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      txd_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      txd_r   <= txd_s;
    end
  end

  // Framer next state: txd is registered with the value of the entered state.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    txd_s   = txd_r;
    pop_s   = 1'b0;
    case (state_r)
      UART_IDLE: begin
        baud_s = BAUD_ZERO;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          state_s = UART_START;
          txd_s   = 1'b0;
        end else begin
          txd_s = 1'b1;
        end
      end
      UART_START: begin
        if (baud_done_s) begin
          baud_s  = BAUD_ZERO;
          idx_s   = 3'd0;
          state_s = UART_DATA;
          txd_s   = shift_r[0];
          shift_s = {1'b0, shift_r[7:1]};
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      UART_DATA: begin
        if (baud_done_s) begin
          baud_s = BAUD_ZERO;
          if (idx_r == 3'd7) begin
            state_s = UART_STOP;
            txd_s   = 1'b1;
          end else begin
            idx_s   = idx_r + 3'd1;
            txd_s   = shift_r[0];
            shift_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      UART_STOP: begin
        if (baud_done_s) begin
          baud_s = BAUD_ZERO;
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rd_ptr_r];
            state_s = UART_START;
            txd_s   = 1'b0;
          end else begin
            state_s = UART_IDLE;
            txd_s   = 1'b1;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_s = UART_IDLE;
        baud_s  = BAUD_ZERO;
        txd_s   = 1'b1;
      end
    endcase
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign level = count_r;
  assign busy  = (state_r != UART_IDLE);
  assign txd   = txd_r;

endmodule

// File: rtl/perip_responder.sv
// Peripheral data-port responder: address decode, switch/LED/7-seg
// registers, free-running timer and a FIFO-buffered UART transmitter.
module perip_responder
  import perip_responder_pkg::*;
#(
  parameter logic [31:0] PERIP_BASE = 32'h8020_0000,
  parameter int          PRESCALE   = 50000,
  parameter int          BAUD_DIV   = 434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] perip_addr,
  input  logic        perip_wen,
  input  logic [2:0]  perip_mask,
  input  logic [31:0] perip_wdata,
  output logic [31:0] perip_rdata,
  output logic        perip_hit,
  input  logic [15:0] sw_in,
  output logic [31:0] led_out,
  output logic [31:0] seg_out,
  output logic        uart_txd
);

  localparam int LW  = $clog2(FIFO_DEPTH) + 32'd1;
  localparam int PSW = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 32'd1;
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 32'd1);
  localparam logic [PSW-1:0] PRESC_ONE  = PSW'(32'd1);

  logic [5:0]    word_s;
  logic [1:0]    lane_s, size_s;
  logic          hit_s, wr_s, aligned_s;
  logic          wr_led_s, wr_seg_s, wr_tctrl_s, wr_udata_s, wr_ustat_s;
  logic [15:0]   sw_meta_r, sw_sync_r;
  logic [31:0]   led_r, seg_r, tval_r, ustat_s, rdata_s;
  logic [PSW-1:0] presc_r;
  logic          en_r, ovf_r;
  logic          u_full_s, u_empty_s, u_busy_s;
  logic [LW-1:0] u_level_s;
  logic [2:0]    lvl3_s;
  logic          unused_s;

  // The load-unsigned flag has no meaning for a responder.
  assign unused_s = perip_mask[2];

  assign hit_s      = (perip_addr[31:8] == PERIP_BASE[31:8]);
  assign word_s     = perip_addr[7:2];
  assign lane_s     = perip_addr[1:0];
  assign size_s     = perip_mask[1:0];
  assign aligned_s  = (lane_s == 2'b00);
  assign wr_s       = perip_wen & hit_s;
  assign wr_led_s   = wr_s & (word_s == OFF_LED[7:2]);
  assign wr_seg_s   = wr_s & (word_s == OFF_SEG[7:2]);
  assign wr_tctrl_s = wr_s & aligned_s & (word_s == OFF_TCTRL[7:2]);
  assign wr_udata_s = wr_s & aligned_s & (word_s == OFF_UDATA[7:2]);
  assign wr_ustat_s = wr_s & aligned_s & (word_s == OFF_USTAT[7:2]);

  // Two-flop synchronizer for the asynchronous switch pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_r <= 16'h0000;
      sw_sync_r <= 16'h0000;
    end else begin
      sw_meta_r <= sw_in;
      sw_sync_r <= sw_meta_r;
    end
  end

  // LED and 7-seg registers with byte/half/word lane merging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= 32'h0000_0000;
      seg_r <= 32'h0000_0000;
    end else begin
      if (wr_led_s) led_r <= merge_store(led_r, perip_wdata, lane_s, size_s);
      if (wr_seg_s) seg_r <= merge_store(seg_r, perip_wdata, lane_s, size_s);
    end
  end

  // Timer: enable bit, prescaler and TVAL; a clear write beats an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r    <= 1'b0;
      presc_r <= {PSW{1'b0}};
      tval_r  <= 32'h0000_0000;
    end else begin
      if (wr_tctrl_s) en_r <= perip_wdata[0];
      if (wr_tctrl_s && perip_wdata[1]) begin
        presc_r <= {PSW{1'b0}};
        tval_r  <= 32'h0000_0000;
      end else if (en_r) begin
        if (presc_r == PRESC_LAST) begin
          presc_r <= {PSW{1'b0}};
          tval_r  <= tval_r + 32'd1;
        end else begin
          presc_r <= presc_r + PRESC_ONE;
        end
      end
    end
  end

  // Sticky overflow: a push into a full FIFO sets it, a write-1 clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (wr_udata_s && u_full_s) begin
      ovf_r <= 1'b1;
    end else if (wr_ustat_s && perip_wdata[USTAT_OVF]) begin
      ovf_r <= 1'b0;
    end
  end

  uart_tx_core #(
    .BAUD_DIV   (BAUD_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LVL_W      (LW)
  ) u_uart (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_udata_s),
    .data  (perip_wdata[7:0]),
    .full  (u_full_s),
    .empty (u_empty_s),
    .level (u_level_s),
    .busy  (u_busy_s),
    .txd   (uart_txd)
  );

  assign lvl3_s = 3'(u_level_s);

  // Word-aligned read mux; anything unmapped or outside the window reads 0.
  always_comb begin
    ustat_s = 32'h0000_0000;
    ustat_s[USTAT_BUSY]     = u_busy_s;
    ustat_s[USTAT_FULL]     = u_full_s;
    ustat_s[USTAT_EMPTY]    = u_empty_s;
    ustat_s[USTAT_LVL +: 3] = lvl3_s;
    ustat_s[USTAT_OVF]      = ovf_r;
    rdata_s = 32'h0000_0000;
    if (hit_s) begin
      case (word_s)
        OFF_SW[7:2]:    rdata_s = {16'h0000, sw_sync_r};
        OFF_LED[7:2]:   rdata_s = led_r;
        OFF_SEG[7:2]:   rdata_s = seg_r;
        OFF_TCTRL[7:2]: rdata_s = {31'h0000_0000, en_r};
        OFF_TVAL[7:2]:  rdata_s = tval_r;
        OFF_USTAT[7:2]: rdata_s = ustat_s;
        default:        rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign perip_rdata = rdata_s;
  assign perip_hit   = hit_s;
  assign led_out     = led_r;
  assign seg_out     = seg_r;

endmodule

// File: tb/tb_perip_responder.sv
// Scoreboard bench for perip_responder: reads and UART frames are queued
// with hand-computed expectations and checked by independent monitors.
module tb_perip_responder;

  localparam logic [31:0] BASE  = 32'h8020_0000;
  localparam logic [2:0]  MBYTE = 3'b000;
  localparam logic [2:0]  MHALF = 3'b001;
  localparam logic [2:0]  MWORD = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] perip_addr = 32'h0;
  logic        perip_wen = 1'b0;
  logic [2:0]  perip_mask = 3'b000;
  logic [31:0] perip_wdata = 32'h0;
  logic [31:0] perip_rdata;
  logic        perip_hit;
  logic [15:0] sw_in = 16'h1234;
  logic [31:0] led_out, seg_out;
  logic        uart_txd;

  always #5 clk = ~clk;

  perip_responder #(
    .PERIP_BASE (BASE),
    .PRESCALE   (4),
    .BAUD_DIV   (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .perip_addr  (perip_addr),
    .perip_wen   (perip_wen),
    .perip_mask  (perip_mask),
    .perip_wdata (perip_wdata),
    .perip_rdata (perip_rdata),
    .perip_hit   (perip_hit),
    .sw_in       (sw_in),
    .led_out     (led_out),
    .seg_out     (seg_out),
    .uart_txd    (uart_txd)
  );

  typedef struct {
    logic [31:0] exp;
    logic [31:0] addr;
  } rd_item_t;

  int          errors = 0;
  int          checks = 0;
  rd_item_t    rd_q[$];
  rd_item_t    rd_it;
  logic [7:0]  uart_q[$];
  logic [7:0]  rx_byte;
  logic        rd_pend = 1'b0;
  logic        mon_en = 1'b1;
  logic        gap_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    perip_addr  = a;
    perip_wdata = d;
    perip_mask  = m;
    perip_wen   = 1'b1;
    @(posedge clk);
    #1;
    perip_wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    perip_addr = a;
    perip_wen  = 1'b0;
    rd_q.push_back('{e, a});
    rd_pend = 1'b1;
    @(posedge clk);
    #1;
    rd_pend = 1'b0;
  endtask

  // Read monitor: compares rdata against the queued expectation mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%08h, expected no read", perip_rdata);
      end else begin
        rd_it = rd_q.pop_front();
        checks++;
        if (perip_rdata !== rd_it.exp) begin
          errors++;
          $display("FAIL rd@%08h: got 0x%08h, expected 0x%08h", rd_it.addr, perip_rdata, rd_it.exp);
        end
      end
    end
  end

  // UART monitor: decodes 2-cycle-per-bit frames and checks back-to-back gaps.
  initial forever begin
    @(negedge clk);
    if (gap_chk) begin
      gap_chk = 1'b0;
      chk("uart_gap", 32'(uart_txd), 32'd0);
    end
    if (mon_en && rst_n && uart_txd == 1'b0) begin
      @(negedge clk);
      chk("uart_start", 32'(uart_txd), 32'd0);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        @(negedge clk);
        rx_byte[i] = uart_txd;
      end
      @(negedge clk);
      @(negedge clk);
      chk("uart_stop", 32'(uart_txd), 32'd1);
      if (uart_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL uart_unexpected: got byte 0x%02h, expected none", rx_byte);
      end else begin
        chk("uart_byte", 32'(rx_byte), 32'(uart_q.pop_front()));
      end
      if (uart_q.size() > 0) gap_chk = 1'b1;
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state and window decode.
    rd(BASE + 32'h04, 32'h0000_0000);
    rd(BASE + 32'h10, 32'h0000_0000);
    rd(BASE + 32'h18, 32'h0000_0004);
    chk("txd_idle", 32'(uart_txd), 32'd1);
    chk("led_reset", led_out, 32'h0000_0000);
    perip_addr = BASE + 32'h04;
    #1;
    chk("hit_in", 32'(perip_hit), 32'd1);
    perip_addr = 32'h8000_0004;
    #1;
    chk("hit_out", 32'(perip_hit), 32'd0);

    // LED/SEG lane writes and misaligned drops.
    wr(BASE + 32'h04, 32'hAABB_CCDD, MWORD);
    wr(BASE + 32'h06, 32'h0000_0011, MBYTE);
    chk("led_byte", led_out, 32'hAA11_CCDD);
    wr(BASE + 32'h05, 32'h0000_FFFF, MHALF);
    chk("led_half_misaligned", led_out, 32'hAA11_CCDD);
    wr(BASE + 32'h06, 32'h1234_5678, MWORD);
    chk("led_word_misaligned", led_out, 32'hAA11_CCDD);
    wr(32'h8000_0004, 32'h0000_0000, MWORD);
    chk("led_outside", led_out, 32'hAA11_CCDD);
    rd(BASE + 32'h06, 32'hAA11_CCDD);
    rd(32'h8000_0004, 32'h0000_0000);
    wr(BASE + 32'h0A, 32'h1234_5678, MHALF);
    chk("seg_half_hi", seg_out, 32'h5678_0000);
    rd(BASE + 32'h00, 32'h0000_1234);
    rd(BASE + 32'h1C, 32'h0000_0000);
    rd(BASE + 32'h14, 32'h0000_0000);

    // Timer: count, clear on the increment cycle, then freeze.
    wr(BASE + 32'h0C, 32'h0000_0001, MWORD);
    cyc(12);
    rd(BASE + 32'h10, 32'h0000_0003);
    cyc(2);
    wr(BASE + 32'h0C, 32'h0000_0003, MWORD);
    rd(BASE + 32'h0C, 32'h0000_0001);
    rd(BASE + 32'h10, 32'h0000_0000);
    cyc(8);
    wr(BASE + 32'h0C, 32'h0000_0000, MWORD);
    cyc(10);
    rd(BASE + 32'h10, 32'h0000_0002);
    rd(BASE + 32'h0C, 32'h0000_0000);

    // Single UART frame of 0x55.
    uart_q.push_back(8'h55);
    wr(BASE + 32'h14, 32'h0000_0055, MBYTE);
    rd(BASE + 32'h18, 32'h0000_0008);
    rd(BASE + 32'h18, 32'h0000_0005);
    cyc(10);
    rd(BASE + 32'h18, 32'h0000_0005);
    cyc(10);
    rd(BASE + 32'h18, 32'h0000_0004);

    // Six back-to-back pushes: five sent, one dropped with overflow.
    uart_q.push_back(8'h11);
    uart_q.push_back(8'h22);
    uart_q.push_back(8'h33);
    uart_q.push_back(8'h44);
    uart_q.push_back(8'h5A);
    wr(BASE + 32'h14, 32'h0000_0011, MBYTE);
    wr(BASE + 32'h14, 32'h0000_0022, MBYTE);
    wr(BASE + 32'h14, 32'h0000_0033, MBYTE);
    wr(BASE + 32'h14, 32'h0000_0044, MBYTE);
    wr(BASE + 32'h14, 32'h0000_005A, MBYTE);
    wr(BASE + 32'h14, 32'h0000_0066, MBYTE);
    rd(BASE + 32'h18, 32'h0000_0063);
    wr(BASE + 32'h18, 32'h0000_0040, MWORD);
    rd(BASE + 32'h18, 32'h0000_0023);
    n = 0;
    while (uart_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (uart_q.size() != 0) begin
      errors++;
      $display("FAIL uart_drain: %0d frames pending, expected 0", uart_q.size());
    end
    cyc(3);
    rd(BASE + 32'h18, 32'h0000_0004);

    // Switch synchronizer latency.
    sw_in = 16'hBEEF;
    rd(BASE + 32'h00, 32'h0000_1234);
    rd(BASE + 32'h00, 32'h0000_1234);
    rd(BASE + 32'h00, 32'h0000_BEEF);

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    wr(BASE + 32'h14, 32'h0000_0000, MBYTE);
    wr(BASE + 32'h14, 32'h0000_0000, MBYTE);
    cyc(4);
    chk("txd_mid_frame", 32'(uart_txd), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("txd_async_reset", 32'(uart_txd), 32'd1);
    rd(BASE + 32'h18, 32'h0000_0004);
    chk("led_async_reset", led_out, 32'h0000_0000);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(5);
    chk("txd_after_reset", 32'(uart_txd), 32'd1);
    rd(BASE + 32'h18, 32'h0000_0004);
    rd(BASE + 32'h04, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perip_responder.md
Name: perip_responder

Overview:
- Bus-responder end of the CPU's peripheral data port. It decodes perip_addr/perip_wen/perip_mask/perip_wdata and returns perip_rdata in the same cycle.
- Hosts a switch input, LED and 7-seg registers, a free-running timer, and a FIFO-buffered UART transmitter.
- Sits beside the DRAM on the data bus. The top level muxes perip_rdata against DRAM using perip_hit.

Parameters:
- PERIP_BASE, 32'h8020_0000, window base; decode uses addr[31:8].
- PRESCALE, 50000, clk cycles per timer tick.
- BAUD_DIV, 434, clk cycles per UART bit.
- FIFO_DEPTH, 4, UART TX FIFO entries (power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- perip_addr  in  32  byte address.
- perip_wen  in  1  write strobe, one cycle per store.
- perip_mask  in  3  size: 3'b000 byte, 3'b001 half, 3'b010 word. Bit2 is the load-unsigned flag and is ignored.
- perip_wdata  in  32  unshifted store data (rs2 value).
- perip_rdata  out  32  aligned full-word read data, combinational.
- perip_hit  out  1  combinational; high when addr[31:8]==PERIP_BASE[31:8].
- sw_in  in  16  asynchronous switch pins.
- led_out  out  32  LED register.
- seg_out  out  32  7-seg register.
- uart_txd  out  1  serial output, idle high.

Behaviour:
- Register map. Offsets are addr[7:0]; reads are word-aligned on addr[7:2].
  - 0x00 SW (RO): {16'b0, sw_sync}.
  - 0x04 LED (RW).
  - 0x08 SEG (RW).
  - 0x0C TCTRL: bit0 enable (RW); bit1 clear (write-1, reads 0).
  - 0x10 TVAL (RO).
  - 0x14 UDATA (WO): push wdata[7:0]; reads 0.
  - 0x18 USTAT: bit0 busy, bit1 full, bit2 empty, [5:3] level, bit6 overflow. Writing 1 to bit6 clears overflow; other bits are RO.
- Other offsets inside the window: read 0, writes ignored. Outside the window: perip_rdata=0, writes ignored.
- Writes to LED/SEG:
  - Byte write: sets lane addr[1:0] from wdata[7:0].
  - Half write: sets lanes {addr[1],0} from wdata[15:0]; ignored if addr[0]=1.
  - Word write: full 32-bit write; ignored if addr[1:0]!=0.
  - Update takes effect at the next clk edge.
- Writes to TCTRL, UDATA and USTAT are honoured only when addr[1:0]==0, at any size.
- Reset values: LED=0, SEG=0, TCTRL=0, TVAL=0, prescaler=0, FIFO empty, overflow=0, uart_txd=1, UART FSM in IDLE, sync flops=0.
- sw_in passes through a 2-flop synchronizer. A pin change is visible on SW reads 2 clk edges later.
- Timer:
  - When enable=1, the prescaler counts 0..PRESCALE-1. At the terminal count it wraps to 0 and TVAL increments; TVAL wraps 0xFFFF_FFFF -> 0.
  - enable=0 freezes both prescaler and TVAL.
  - A clear write zeroes TVAL and the prescaler at the next edge. Clear beats a same-cycle increment. The enable bit comes from the same write.
- UART FIFO:
  - A push when the FIFO is full, judged on the level before the cycle, is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves the level unchanged.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop, load the shift register, enter START. uart_txd goes 0 on the following edge.
  - Each state lasts BAUD_DIV cycles.
  - DATA sends 8 bits LSB first, counted by a 3-bit index.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
  - busy=1 whenever the state is not IDLE.
- Reset asserted mid-frame immediately forces uart_txd=1 and empties the FIFO. The partial frame is lost.

Decomposition:
- Shared package holds:
  - Register offset localparams.
  - Mask encodings (SZ_BYTE/SZ_HALF/SZ_WORD).
  - UART state enum.
  - USTAT bit positions.
- One sub-module, uart_tx_core, contains the FIFO, baud counter and FSM. Its interface is push/data/full/empty/level/busy/txd.
- Decode, registers and timer stay in perip_responder.

Test Plan:
1. Reset, then read offsets 0x04, 0x10 and 0x18 -> rdata 0, 0 and 0x0000_0004 (empty=1); uart_txd=1; perip_hit=1 for 0x8020_0004 and 0 for 0x8000_0004.
2. Word write 0x04=0xAABBCCDD, then byte write to 0x06 with wdata 0x11 -> led_out=0xAA11CCDD. Then half write to 0x05 (misaligned) -> unchanged.
3. With PRESCALE=4, write TCTRL=1 and wait 12 cycles -> TVAL=3. Write TCTRL=3 in the cycle TVAL would increment -> TVAL=0. Then TCTRL=0 -> TVAL holds.
4. With BAUD_DIV=2, push 0x55 -> uart_txd sequence: 0 for 2 cycles, then 1,0,1,0,1,0,1,0 (2 cycles each), then 1. busy=1 throughout; empty=1 after the pop.
5. Push 6 bytes back-to-back while idle -> first byte popped, 4 queued, 1 dropped; overflow=1. Frames are contiguous with no idle between stop and start. Writing USTAT=0x40 -> overflow=0.
6. Toggle sw_in=0xBEEF -> SW reads old value for 2 edges, then 0x0000BEEF. Assert rst_n=0 mid-frame -> uart_txd=1 immediately and level=0.
